// File: rtl/tmds_encoder_rgb.sv
// Three-channel DVI TMDS 8b/10b encoder.
// Two registered stages: transition-minimise, then DC balance.
module tmds_encoder_rgb #(
  parameter bit SWAP_RB = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] pixel,
  output logic [9:0]  tmds0,
  output logic [9:0]  tmds1,
  output logic [9:0]  tmds2,
  output logic        de_out
);

  logic [2:0][7:0] byte_w;
  logic            de_s1_d, de_s1_q;
  logic [1:0]      ctl_d, ctl_q;
  logic [2:0][8:0] qm_d, qm_q;
  logic [2:0][9:0] tmds_d, tmds_q;
  logic [2:0][5:0] cnt_d, cnt_q;
  logic            de_out_d, de_out_q;

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, d[i]};
    return n;
  endfunction

  function automatic logic [8:0] qm_enc(input logic [7:0] d);
    logic [3:0] n;
    logic       xn;
    logic [8:0] q;
    n  = ones8(d);
    xn = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q  = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

  // returns {cnt_next, symbol}
  function automatic logic [15:0] enc2(
    input logic       den,
    input logic [1:0] c,
    input logic [8:0] qm,
    input logic [5:0] cnt
  );
    logic [3:0] n1, n0;
    logic [5:0] diff, cn;
    logic [9:0] sym;
    n1   = ones8(qm[7:0]);
    n0   = 4'd8 - n1;
    diff = {2'b00, n1} - {2'b00, n0};
    if (!den) begin
      cn = 6'd0;
      case (c)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
    end else if ((cnt == 6'd0) || (n1 == n0)) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cn  = qm[8] ? cnt + diff : cnt - diff;
    end else if ((!cnt[5] && (n1 > n0)) || (cnt[5] && (n0 > n1))) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cn  = cnt + {4'd0, qm[8], 1'b0} - diff;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cn  = cnt - {4'd0, ~qm[8], 1'b0} + diff;
    end
    return {cn, sym};
  endfunction

  // stage 1: lane select and transition-minimised byte
  always_comb begin
    byte_w[0] = SWAP_RB ? pixel[23:16] : pixel[7:0];
    byte_w[1] = pixel[15:8];
    byte_w[2] = SWAP_RB ? pixel[7:0] : pixel[23:16];
    de_s1_d   = de;
    ctl_d     = {vsync, hsync};
    for (int k = 0; k < 3; k++) qm_d[k] = qm_enc(byte_w[k]);
  end

  // stage 2: DC balance per channel, control symbols in blanking
  always_comb begin
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      r = enc2(de_s1_q, (k == 0) ? ctl_q : 2'b00, qm_q[k], cnt_q[k]);
      tmds_d[k] = r[9:0];
      cnt_d[k]  = r[15:10];
    end
    de_out_d = de_s1_q;
  end

  // pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_s1_q  <= 1'b0;
      ctl_q    <= 2'b00;
      qm_q     <= '0;
      tmds_q   <= {3{10'h354}};
      cnt_q    <= '0;
      de_out_q <= 1'b0;
    end else begin
      de_s1_q  <= de_s1_d;
      ctl_q    <= ctl_d;
      qm_q     <= qm_d;
      tmds_q   <= tmds_d;
      cnt_q    <= cnt_d;
      de_out_q <= de_out_d;
    end
  end

  assign tmds0  = tmds_q[0];
  assign tmds1  = tmds_q[1];
  assign tmds2  = tmds_q[2];
  assign de_out = de_out_q;

endmodule

// File: tb/tb_tmds_encoder_rgb.sv
// Bench for tmds_encoder_rgb: directed vectors plus
// a randomized run against a behavioural model.
module tb_tmds_encoder_rgb;

  logic        clk, rst, de, hsync, vsync;
  logic [23:0] pixel;
  logic [9:0]  tmds0, tmds1, tmds2;
  logic        de_out;
  logic [9:0]  sw0, sw1, sw2;
  logic        sw_de;

  int n_chk  = 0;
  int n_pass = 0;

  tmds_encoder_rgb dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync),
    .vsync(vsync), .pixel(pixel), .tmds0(tmds0),
    .tmds1(tmds1), .tmds2(tmds2), .de_out(de_out)
  );

  tmds_encoder_rgb #(.SWAP_RB(1'b1)) dut_sw (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync),
    .vsync(vsync), .pixel(pixel), .tmds0(sw0),
    .tmds1(sw1), .tmds2(sw2), .de_out(sw_de)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] ref_enc(
    input  logic [7:0] d,
    input  logic       den,
    input  logic [1:0] c,
    input  int         cin,
    output int         cout
  );
    int ones, n1, n0;
    logic xn;
    logic [8:0] qm;
    logic [9:0] sym;
    ones = $countones(d);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (!den) begin
      cout = 0;
      case (c)
        2'd0: sym = 10'h354;
        2'd1: sym = 10'h0AB;
        2'd2: sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
    end else if (cin == 0 || n1 == n0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cout = qm[8] ? cin + n1 - n0 : cin + n0 - n1;
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cout = cin + 2 * int'(qm[8]) + n0 - n1;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cout = cin - 2 * int'(!qm[8]) + n1 - n0;
    end
    return sym;
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] d, b;
    d = s[9] ? ~s[7:0] : s[7:0];
    b = '0;
    b[0] = d[0];
    for (int i = 1; i < 8; i++)
      b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return b;
  endfunction

  logic [9:0] ctab [4];
  int mc [3];
  int maxabs;

  initial begin
    logic [9:0]  e0, e1, e2;
    logic        p_de, p_hs, p_vs;
    logic [23:0] p_px;
    int          pos, v;

    ctab[0] = 10'h354; ctab[1] = 10'h0AB;
    ctab[2] = 10'h154; ctab[3] = 10'h2AB;
    rst = 1'b0; de = 1'b0; hsync = 1'b0;
    vsync = 1'b0; pixel = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_tmds0", tmds0, 10'h354);
    chk("rst_tmds1", tmds1, 10'h354);
    chk("rst_tmds2", tmds2, 10'h354);
    chk("rst_deout", de_out, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // blank with hsync: exact 2-clock latency
    hsync = 1'b1;
    tick();
    chk("lat1_tmds0", tmds0, 10'h354);
    tick();
    chk("hs_tmds0", tmds0, 10'h0AB);
    chk("hs_tmds1", tmds1, 10'h354);
    chk("hs_tmds2", tmds2, 10'h354);
    chk("hs_deout", de_out, 1'b0);

    for (int c = 0; c < 4; c++) begin
      hsync = c[0];
      vsync = c[1];
      tick(); tick();
      chk($sformatf("ctl%0d", c), tmds0, ctab[c]);
    end
    hsync = 1'b0; vsync = 1'b0;
    tick(); tick();

    // blue=0 three times: 0x100, 0x3FF, 0x100
    de = 1'b1; pixel = 24'h000000;
    tick();
    tick();
    chk("b0_sym1", tmds0, 10'h100);
    chk("b0_cnt1", dut.cnt_q[0], 6'h38);
    chk("b0_de1", de_out, 1'b1);
    chk("b0_g1", tmds1, 10'h100);
    tick();
    chk("b0_sym2", tmds0, 10'h3FF);
    chk("b0_cnt2", dut.cnt_q[0], 6'h02);
    de = 1'b0;
    tick();
    chk("b0_sym3", tmds0, 10'h100);
    chk("b0_cnt3", dut.cnt_q[0], 6'h3A);
    tick();
    chk("fall_sym", tmds0, 10'h354);
    chk("fall_cnt", dut.cnt_q[0], 6'h00);
    chk("fall_de", de_out, 1'b0);

    // green=0xFF alone
    de = 1'b1; pixel = 24'h00FF00;
    tick();
    de = 1'b0;
    tick();
    chk("g_tmds1", tmds1, 10'h200);
    chk("g_cnt1", dut.cnt_q[1], 6'h38);
    chk("g_tmds0", tmds0, 10'h100);
    chk("g_tmds2", tmds2, 10'h100);
    tick();

    // red=0xFF, swapped instance moves it to tmds0
    de = 1'b1; pixel = 24'hFF0000;
    tick();
    de = 1'b0;
    tick();
    chk("r_tmds2", tmds2, 10'h200);
    chk("r_tmds0", tmds0, 10'h100);
    chk("sw_tmds0", sw0, 10'h200);
    chk("sw_tmds2", sw2, 10'h100);
    tick();

    // reset mid-line with nonzero disparity
    de = 1'b1; pixel = 24'h000000;
    tick(); tick();
    chk("mid_cnt", dut.cnt_q[0], 6'h38);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_t0", tmds0, 10'h354);
    chk("mid_rst_de", de_out, 1'b0);
    chk("mid_rst_cnt", dut.cnt_q[0], 6'h00);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_t0", tmds0, 10'h100);
    de = 1'b0;
    tick(); tick();

    // randomized run against the model
    p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_px = '0;
    hsync = 1'b0; vsync = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) mc[k] = 0;
    maxabs = 0;
    for (int i = 0; i < 3000; i++) begin
      pos   = i % 48;
      de    = (pos >= 8 && pos < 44);
      if ($urandom_range(0, 15) == 0) de = ~de;
      hsync = (pos < 4);
      vsync = ((i / 48) % 8 == 0);
      pixel = 24'($urandom);
      tick();
      e0 = ref_enc(p_px[7:0], p_de, {p_vs, p_hs}, mc[0], mc[0]);
      e1 = ref_enc(p_px[15:8], p_de, 2'b00, mc[1], mc[1]);
      e2 = ref_enc(p_px[23:16], p_de, 2'b00, mc[2], mc[2]);
      chk($sformatf("rnd%0d", i), {de_out, tmds2, tmds1, tmds0},
          {p_de, e2, e1, e0});
      if (p_de)
        chk($sformatf("dec%0d", i),
            {dec(tmds2), dec(tmds1), dec(tmds0)}, p_px);
      for (int k = 0; k < 3; k++) begin
        v = int'($signed(dut.cnt_q[k]));
        if (v < 0) v = -v;
        if (v > maxabs) maxabs = v;
      end
      p_de = de; p_hs = hsync; p_vs = vsync; p_px = pixel;
    end
    chk("cnt_bound", (maxabs <= 10), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
